// File: rtl/psg_bus_pkg.sv
// Shared types and constants for the PSG bus driver: FSM states, bus codes
// and the packed command word carried through the command FIFO.
package psg_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AGAP,
    ST_WR,
    ST_RD,
    ST_GAP
  } state_e;

  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_ADDR  = 2'b11;

  localparam int unsigned CMD_W = 13;

  localparam logic [3:0] ADDR_MASK = 4'b0000;

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  function automatic logic [1:0] bus_code(input state_e s);
    case (s)
      ST_ADDR: return BUS_ADDR;
      ST_WR:   return BUS_WRITE;
      ST_RD:   return BUS_READ;
      default: return BUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/psg_bus_driver_if.sv
// System-side command/response handshake plus the PSG-facing bdir/bc1 bus.
interface psg_bus_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       bdir;
  logic       bc1;
  logic [7:0] d_out;
  logic [7:0] q_in;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, q_in,
    output req_ready, rsp_valid, rsp_data, busy, bdir, bc1, d_out
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, q_in,
    input  req_ready, rsp_valid, rsp_data, busy, bdir, bc1, d_out
  );
endinterface

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module psg_cmd_fifo
  import psg_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psg_bus_driver.sv
// Converts queued PSG register read/write commands into sequenced
// address-latch / write / read bdir-bc1 bus cycles, with optional address caching.
module psg_bus_driver
  import psg_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned ADDR_CACHE  = 1
) (
  input logic              clock,
  input logic              reset,
  input logic              ce,
  psg_bus_driver_if.slave  bus
);

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  cmd_t       cmd_q, cmd_d;
  logic [3:0] cache_addr_q;
  logic       cache_vld_q;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] bus_q, bus_d;
  logic [7:0] dout_q, dout_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0] fifo_dout;
  cmd_t             head, req_cmd;
  logic             hold_done, cache_hit, cache_load, rsp_fire;

  assign req_cmd = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
  assign head    = cmd_t'(fifo_dout);

  psg_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (bus.req_valid),
    .pop  (fifo_pop),
    .din  (req_cmd),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign hold_done  = (hold_q == '0);
  assign cache_hit  = (ADDR_CACHE != 0) && cache_vld_q && (cache_addr_q == head.addr);
  assign fifo_pop   = ce && (state_q == ST_IDLE) && !fifo_empty;
  assign cache_load = ce && (state_q == ST_ADDR) && hold_done;
  assign rsp_fire   = ce && (state_q == ST_RD) && hold_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= HOLD_RELOAD;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = fifo_pop ? head : cmd_q;
    if (ce) begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) state_d = cache_hit ? (head.write ? ST_WR : ST_RD) : ST_ADDR;
        ST_ADDR: if (hold_done) state_d = ST_AGAP;
        ST_AGAP: state_d = cmd_q.write ? ST_WR : ST_RD;
        ST_WR,
        ST_RD:   if (hold_done) state_d = ST_GAP;
        ST_GAP:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Reload on every state change so each phase starts a fresh hold count.
    hold_d = hold_q;
    if (ce) begin
      if (state_d != state_q)  hold_d = HOLD_RELOAD;
      else if (!hold_done)     hold_d = hold_q - 4'd1;
    end
  end

  // Bus outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to.
  always_comb begin
    bus_d  = bus_code(state_d);
    dout_d = '0;
    case (state_d)
      ST_ADDR: dout_d = {ADDR_MASK, cmd_d.addr};
      ST_WR:   dout_d = cmd_d.wdata;
      default: dout_d = '0;
    endcase
    rsp_valid_d = rsp_fire;
    rsp_data_d  = rsp_fire ? bus.q_in : rsp_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q        <= '0;
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      bus_q        <= BUS_IDLE;
      dout_q       <= '0;
    end else begin
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      bus_q       <= bus_d;
      dout_q      <= dout_d;
      if (cache_load) begin
        cache_addr_q <= cmd_q.addr;
        cache_vld_q  <= 1'b1;
      end
    end
  end

  assign bus.req_ready = ~fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = ~fifo_empty | (state_q != ST_IDLE);
  assign bus.bdir      = bus_q[1];
  assign bus.bc1       = bus_q[0];
  assign bus.d_out     = dout_q;

endmodule

// File: tb/tb_psg_bus_driver.sv
// Directed bench for psg_bus_driver: a HOLD=1 instance with a small PSG model
// and a HOLD=3 instance driven with ce every other clock.
module tb_psg_bus_driver;

  logic clk = 1'b0;
  logic rst;
  logic ce_a;
  logic ce_b;

  int total = 0;
  int bad   = 0;

  psg_bus_driver_if ifa ();
  psg_bus_driver_if ifb ();

  psg_bus_driver #(
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(1),
    .ADDR_CACHE (1)
  ) u_dut (
    .clock(clk),
    .reset(rst),
    .ce   (ce_a),
    .bus  (ifa.slave)
  );

  psg_bus_driver #(
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(3),
    .ADDR_CACHE (1)
  ) u_dut_h3 (
    .clock(clk),
    .reset(rst),
    .ce   (ce_b),
    .bus  (ifb.slave)
  );

  always #5 clk = ~clk;

  // PSG register-file model attached to the HOLD=1 instance
  logic [7:0] psg_reg [16] = '{14: 8'hA5, default: 8'h00};
  logic [3:0] psg_lat = 4'h0;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wr_log[$];
  int  rsp_cnt = 0;

  always @(posedge clk) begin
    if ({ifa.bdir, ifa.bc1} == 2'b11) psg_lat <= ifa.d_out[3:0];
    if ({ifa.bdir, ifa.bc1} == 2'b10) begin
      psg_reg[psg_lat] <= ifa.d_out;
      if (ce_a) wr_log.push_back('{a: psg_lat, d: ifa.d_out});
    end
    if (ifa.rsp_valid) rsp_cnt++;
  end

  assign ifa.q_in = ({ifa.bdir, ifa.bc1} == 2'b01) ? psg_reg[psg_lat] : 8'h00;
  assign ifb.q_in = 8'h5A;

  logic [1:0] tr [40];
  logic       bb [40];
  logic [7:0] dd [40];
  int         idx;
  int         n;
  int         r0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic w, input logic [3:0] a, input logic [7:0] d);
    ifa.req_valid = 1'b1;
    ifa.req_write = w;
    ifa.req_addr  = a;
    ifa.req_wdata = d;
    step();
    ifa.req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ce_a = 1'b1;
    ce_b = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ifa.req_ready, 1);
    chk("rst_rsp_valid", ifa.rsp_valid, 0);
    chk("rst_rsp_data", ifa.rsp_data, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_bus", {ifa.bdir, ifa.bc1}, 0);
    chk("rst_dout", ifa.d_out, 0);
    rst = 1'b0;
    step();

    // write R7 = 0x38, cache miss
    push_a(1'b1, 4'd7, 8'h38);
    chk("t1_busy_queued", ifa.busy, 1);
    chk("t1_idle", {ifa.bdir, ifa.bc1}, 0);
    step();
    chk("t1_addr", {ifa.bdir, ifa.bc1}, 3);
    chk("t1_addr_d", ifa.d_out, 8'h07);
    step();
    chk("t1_agap", {ifa.bdir, ifa.bc1}, 0);
    step();
    chk("t1_wr", {ifa.bdir, ifa.bc1}, 2);
    chk("t1_wr_d", ifa.d_out, 8'h38);
    step();
    chk("t1_gap", {ifa.bdir, ifa.bc1}, 0);
    chk("t1_gap_busy", ifa.busy, 1);
    step();
    chk("t1_busy_fall", ifa.busy, 0);
    chk("t1_psg_r7", psg_reg[7], 8'h38);

    // back-to-back writes to R8: second one hits the cache
    push_a(1'b1, 4'd8, 8'h0F);
    push_a(1'b1, 4'd8, 8'h1F);
    chk("t2_addr", {ifa.bdir, ifa.bc1}, 3);
    chk("t2_addr_d", ifa.d_out, 8'h08);
    step();
    chk("t2_agap", {ifa.bdir, ifa.bc1}, 0);
    step();
    chk("t2_wr1", {ifa.bdir, ifa.bc1}, 2);
    chk("t2_wr1_d", ifa.d_out, 8'h0F);
    step();
    chk("t2_gap1", {ifa.bdir, ifa.bc1}, 0);
    step();
    chk("t2_idle", {ifa.bdir, ifa.bc1}, 0);
    chk("t2_idle_busy", ifa.busy, 1);
    step();
    chk("t2_wr2_noaddr", {ifa.bdir, ifa.bc1}, 2);
    chk("t2_wr2_d", ifa.d_out, 8'h1F);
    step();
    chk("t2_gap2", {ifa.bdir, ifa.bc1}, 0);
    step();
    chk("t2_busy_fall", ifa.busy, 0);
    chk("t2_psg_r8", psg_reg[8], 8'h1F);

    // read R14, model returns 0xA5
    r0 = rsp_cnt;
    push_a(1'b0, 4'd14, 8'h00);
    step();
    chk("t3_addr", {ifa.bdir, ifa.bc1}, 3);
    chk("t3_addr_d", ifa.d_out, 8'h0E);
    step();
    chk("t3_agap", {ifa.bdir, ifa.bc1}, 0);
    step();
    chk("t3_rd", {ifa.bdir, ifa.bc1}, 1);
    chk("t3_rd_d", ifa.d_out, 0);
    chk("t3_rsp_early", ifa.rsp_valid, 0);
    step();
    chk("t3_gap", {ifa.bdir, ifa.bc1}, 0);
    chk("t3_rsp_valid", ifa.rsp_valid, 1);
    chk("t3_rsp_data", ifa.rsp_data, 8'hA5);
    step();
    chk("t3_rsp_pulse_end", ifa.rsp_valid, 0);
    chk("t3_rsp_hold", ifa.rsp_data, 8'hA5);
    chk("t3_busy_fall", ifa.busy, 0);
    step();
    chk("t3_rsp_count", rsp_cnt - r0, 1);

    // fill FIFO with ce low; fifth push must be refused
    ce_a = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      chk("t4_ready_before_push", ifa.req_ready, (i < 4) ? 1 : 0);
      push_a(1'b1, 4'(i + 1), 8'((i + 1) * 17));
    end
    chk("t4_ready_full", ifa.req_ready, 0);
    chk("t4_frozen_bus", {ifa.bdir, ifa.bc1}, 0);
    ce_a = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!ifa.busy) break;
      step();
    end
    chk("t4_drain_done", ifa.busy, 0);
    chk("t4_log_size", wr_log.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < wr_log.size()) begin
        chk("t4_order_addr", wr_log[j].a, j + 1);
        chk("t4_order_data", wr_log[j].d, (j + 1) * 17);
      end
    end
    chk("t4_r5_untouched", psg_reg[5], 0);
    chk("t4_ready_back", ifa.req_ready, 1);

    // HOLD=3 instance, ce every other clock
    ifb.req_valid = 1'b1;
    ifb.req_write = 1'b1;
    ifb.req_addr  = 4'd3;
    ifb.req_wdata = 8'hC3;
    step();
    ifb.req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ce_b = (k % 2 == 0);
      step();
      tr[k] = {ifb.bdir, ifb.bc1};
      bb[k] = ifb.busy;
      dd[k] = ifb.d_out;
    end
    ce_b = 1'b0;
    idx = 0;
    while (idx < 40 && tr[idx] != 2'b11) idx++;
    chk("t5_addr_d", (idx < 40) ? dd[idx] : -1, 8'h03);
    n = 0;
    while (idx < 40 && tr[idx] == 2'b11) begin n++; idx++; end
    chk("t5_addr_len", n, 6);
    n = 0;
    while (idx < 40 && tr[idx] == 2'b00) begin n++; idx++; end
    chk("t5_agap_len", n, 2);
    chk("t5_wr_d", (idx < 40) ? dd[idx] : -1, 8'hC3);
    n = 0;
    while (idx < 40 && tr[idx] == 2'b10) begin n++; idx++; end
    chk("t5_wr_len", n, 6);
    n = 0;
    while (idx < 40 && bb[idx]) begin n++; idx++; end
    chk("t5_gap_len", n, 2);

    // reset during WR phase
    r0 = rsp_cnt;
    push_a(1'b1, 4'd9, 8'h99);
    step();
    chk("t6_addr", {ifa.bdir, ifa.bc1}, 3);
    push_a(1'b1, 4'd10, 8'hAA);
    step();
    chk("t6_wr", {ifa.bdir, ifa.bc1}, 2);
    chk("t6_wr_d", ifa.d_out, 8'h99);
    #1 rst = 1'b1;
    #1;
    chk("t6_abort_bus", {ifa.bdir, ifa.bc1}, 0);
    chk("t6_abort_busy", ifa.busy, 0);
    chk("t6_abort_ready", ifa.req_ready, 1);
    #2 rst = 1'b0;
    repeat (3) step();
    chk("t6_stay_idle", {ifa.bdir, ifa.bc1}, 0);
    chk("t6_no_rsp", rsp_cnt - r0, 0);
    chk("t6_r9_unwritten", psg_reg[9], 0);
    chk("t6_r10_unwritten", psg_reg[10], 0);
    push_a(1'b1, 4'd9, 8'h77);
    step();
    chk("t6_readdr", {ifa.bdir, ifa.bc1}, 3);
    chk("t6_readdr_d", ifa.d_out, 8'h09);
    repeat (4) step();
    chk("t6_busy_fall", ifa.busy, 0);
    chk("t6_r9", psg_reg[9], 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
